// File: rtl/str_fanout.sv
// Avalon-ST sink broadcast to two HLS call branches, each with its own FWFT FIFO.
// Optional statistics counters are built only when FANOUT_STATS_EN is defined.
module str_fanout #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_startofpacket,
  input  logic              in_endofpacket,
  output logic              in_ready,
  output logic              call0_valid,
  input  logic              call0_stall,
  output logic [DATA_W-1:0] symbol0_data,
  output logic              sop0_data,
  output logic              call1_valid,
  input  logic              call1_stall,
  output logic [DATA_W-1:0] symbol1_data,
  output logic              sop1_data,
  input  logic              err_clr,
  output logic              err_framing,
  output logic [31:0]       stall_cnt0,
  output logic [31:0]       stall_cnt1,
  output logic [31:0]       pkt_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = DATA_W + 2;

  typedef enum logic {IDLE, IN_PKT} state_t;

  logic              rdy_q;
  logic              push;
  logic [1:0]        stall;
  logic [1:0]        valid;
  logic [1:0]        full;
  logic [1:0]        pop;
  logic [1:0]        head_sop;
  logic [DATA_W-1:0] head_data [2];
  state_t            state, state_nxt;
  logic              err_set;

  assign stall    = {call1_stall, call0_stall};
  // rdy_q keeps the sink closed during reset and opens it on the first edge after
  assign in_ready = rdy_q && !full[0] && !full[1];
  assign push     = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  for (genvar k = 0; k < 2; k++) begin : g_br
    logic [WW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop[k]) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop[k]})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_startofpacket, in_endofpacket, in_data};
    end

    assign valid[k]     = (cnt != '0);
    assign full[k]      = (cnt == CW'(DEPTH));
    assign pop[k]       = valid[k] && !stall[k];
    assign head_data[k] = mem[rd_ptr][DATA_W-1:0];
    assign head_sop[k]  = mem[rd_ptr][WW-1];
  end

  assign call0_valid  = valid[0];
  assign call1_valid  = valid[1];
  assign symbol0_data = head_data[0];
  assign symbol1_data = head_data[1];
  assign sop0_data    = head_sop[0];
  assign sop1_data    = head_sop[1];

  // Framing check: an out-of-place SOP restarts the packet, the word still goes through
  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    if (push) begin
      err_set = (state == IDLE) ? !in_startofpacket : in_startofpacket;
      if (in_startofpacket)    state_nxt = in_endofpacket ? IDLE : IN_PKT;
      else if (in_endofpacket) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      err_framing <= 1'b0;
    end else begin
      state <= state_nxt;
      if (err_set)      err_framing <= 1'b1;
      else if (err_clr) err_framing <= 1'b0;
    end
  end

`ifdef FANOUT_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt0 <= '0;
      stall_cnt1 <= '0;
      pkt_cnt    <= '0;
    end else begin
      if (valid[0] && stall[0])     stall_cnt0 <= sat_inc(stall_cnt0);
      if (valid[1] && stall[1])     stall_cnt1 <= sat_inc(stall_cnt1);
      if (push && in_endofpacket)   pkt_cnt    <= sat_inc(pkt_cnt);
    end
  end
`else
  assign stall_cnt0 = '0;
  assign stall_cnt1 = '0;
  assign pkt_cnt    = '0;
`endif
endmodule

// File: tb/tb_str_fanout.sv
// Directed bench for str_fanout: broadcast, back-pressure, full FIFOs, framing, reset, stats.
module tb_str_fanout;
  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_sop, in_eop;
  logic        in_ready;
  logic        call0_valid, call1_valid;
  logic        call0_stall, call1_stall;
  logic [7:0]  symbol0_data, symbol1_data;
  logic        sop0_data, sop1_data;
  logic        err_clr, err_framing;
  logic [31:0] stall_cnt0, stall_cnt1, pkt_cnt;

  int checks = 0;
  int failures = 0;
  logic [8:0] q0[$];
  logic [8:0] q1[$];

  str_fanout #(.DEPTH(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid),
    .in_startofpacket(in_sop), .in_endofpacket(in_eop), .in_ready(in_ready),
    .call0_valid(call0_valid), .call0_stall(call0_stall),
    .symbol0_data(symbol0_data), .sop0_data(sop0_data),
    .call1_valid(call1_valid), .call1_stall(call1_stall),
    .symbol1_data(symbol1_data), .sop1_data(sop1_data),
    .err_clr(err_clr), .err_framing(err_framing),
    .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1), .pkt_cnt(pkt_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every word a branch consumes; inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (call0_valid && !call0_stall) q0.push_back({sop0_data, symbol0_data});
    if (call1_valid && !call1_stall) q1.push_back({sop1_data, symbol1_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [8:0] got[$], input logic [8:0] exp[$]);
    chk({tag, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (i < got.size()) chk($sformatf("%s_w%0d", tag, i), {23'd0, got[i]}, {23'd0, exp[i]});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s, input logic e, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_sop = s; in_eop = e; in_data = d;
    for (int i = 0; i < 50; i++) begin
      ok = in_ready;
      step();
      if (ok) break;
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((call0_valid || call1_valid) && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'd0, 32'd1);
    step();
  endtask

  initial begin
    logic [8:0] exp[$];
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    call0_stall = 1'b0; call1_stall = 1'b0; err_clr = 1'b0;

    // Reset state
    step(); step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_call0_valid", {31'd0, call0_valid}, 32'd0);
    chk("rst_call1_valid", {31'd0, call1_valid}, 32'd0);
    chk("rst_err", {31'd0, err_framing}, 32'd0);
    chk("rst_pkt_cnt", pkt_cnt, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 8-byte packet, no stalls
    send(1'b1, 1'b0, 8'h41);
    chk("t1_call0_valid_lat", {31'd0, call0_valid}, 32'd1);
    chk("t1_call1_valid_lat", {31'd0, call1_valid}, 32'd1);
    chk("t1_head0", {24'd0, symbol0_data}, 32'h41);
    chk("t1_sop0", {31'd0, sop0_data}, 32'd1);
    for (int i = 1; i < 8; i++) send(1'b0, i == 7, 8'(8'h41 + i));
    drain();
    exp = {9'h141, 9'h042, 9'h043, 9'h044, 9'h045, 9'h046, 9'h047, 9'h048};
    chk_q("t1_b0", q0, exp);
    chk_q("t1_b1", q1, exp);
    q0.delete(); q1.delete();

    // Branch 1 stalled: back-pressure after 4 accepts, branch 0 keeps flowing
    call1_stall = 1'b1;
    for (int i = 0; i < 4; i++) send(i == 0, 1'b0, 8'(8'h10 + i));
    chk("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("t2_b0_count_mid", q0.size(), 32'd3);
    in_valid = 1'b1; in_data = 8'h14;
    step(); step(); step();
    chk("t2_still_blocked", {31'd0, in_ready}, 32'd0);
    call1_stall = 1'b0;
    send(1'b0, 1'b0, 8'h14);
    send(1'b0, 1'b1, 8'h15);
    drain();
    exp = {9'h110, 9'h011, 9'h012, 9'h013, 9'h014, 9'h015};
    chk_q("t2_b0", q0, exp);
    chk_q("t2_b1", q1, exp);
    q0.delete(); q1.delete();

    // Both FIFOs full, pop with a pending push attempt
    call0_stall = 1'b1; call1_stall = 1'b1;
    for (int i = 0; i < 4; i++) send(i == 0, 1'b0, 8'(8'h20 + i));
    chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_sop = 1'b0; in_eop = 1'b1; in_data = 8'h24;
    call0_stall = 1'b0;
    step();
    chk("t3_b1_still_full", {31'd0, in_ready}, 32'd0);
    call1_stall = 1'b0;
    step();
    chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
    send(1'b0, 1'b1, 8'h24);
    drain();
    exp = {9'h120, 9'h021, 9'h022, 9'h023, 9'h024};
    chk_q("t3_b0", q0, exp);
    chk_q("t3_b1", q1, exp);
    q0.delete(); q1.delete();

    // Framing errors
    chk("t4_err_clean", {31'd0, err_framing}, 32'd0);
    send(1'b1, 1'b0, 8'h30);
    chk("t4_err_first_sop", {31'd0, err_framing}, 32'd0);
    send(1'b1, 1'b0, 8'h31);
    chk("t4_err_double_sop", {31'd0, err_framing}, 32'd1);
    step(); step(); step();
    chk("t4_err_sticky", {31'd0, err_framing}, 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t4_err_cleared", {31'd0, err_framing}, 32'd0);
    send(1'b0, 1'b1, 8'h32);
    chk("t4_err_after_eop", {31'd0, err_framing}, 32'd0);
    err_clr = 1'b1;
    send(1'b0, 1'b1, 8'h33);
    err_clr = 1'b0;
    chk("t4_set_wins", {31'd0, err_framing}, 32'd1);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t4_err_cleared2", {31'd0, err_framing}, 32'd0);
    drain();
    exp = {9'h130, 9'h131, 9'h032, 9'h033};
    chk_q("t4_b0", q0, exp);
    q0.delete(); q1.delete();

    // Reset with 3 buffered words mid-packet
    call0_stall = 1'b1; call1_stall = 1'b1;
    for (int i = 0; i < 3; i++) send(i == 0, 1'b0, 8'(8'h50 + i));
    chk("t5_buffered", {31'd0, call0_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_v0", {31'd0, call0_valid}, 32'd0);
    chk("t5_rst_v1", {31'd0, call1_valid}, 32'd0);
    chk("t5_rst_ready", {31'd0, in_ready}, 32'd0);
    chk("t5_rst_sc0", stall_cnt0, 32'd0);
    chk("t5_rst_sc1", stall_cnt1, 32'd0);
    chk("t5_rst_pkt", pkt_cnt, 32'd0);
    step();
    rst = 1'b0;
    call0_stall = 1'b0; call1_stall = 1'b0;
    step();
    chk("t5_ready_after", {31'd0, in_ready}, 32'd1);
    chk("t5_v0_after", {31'd0, call0_valid}, 32'd0);
    q0.delete(); q1.delete();
    send(1'b1, 1'b0, 8'h60);
    send(1'b0, 1'b0, 8'h61);
    send(1'b0, 1'b1, 8'h62);
    drain();
    exp = {9'h160, 9'h061, 9'h062};
    chk_q("t5_b0", q0, exp);
    chk_q("t5_b1", q1, exp);
    chk("t5_err", {31'd0, err_framing}, 32'd0);
    q0.delete(); q1.delete();

    // Statistics: 10 stall cycles on branch 0, three packets since reset
    call0_stall = 1'b1;
    send(1'b1, 1'b1, 8'h70);
    for (int i = 0; i < 9; i++) step();
    chk("t6_v0_pending", {31'd0, call0_valid}, 32'd1);
    step();
    call0_stall = 1'b0;
    send(1'b1, 1'b1, 8'h71);
    drain();
`ifdef FANOUT_STATS_EN
    chk("t6_stall_cnt0", stall_cnt0, 32'd10);
    chk("t6_stall_cnt1", stall_cnt1, 32'd0);
    chk("t6_pkt_cnt", pkt_cnt, 32'd3);
`else
    chk("t6_stall_cnt0", stall_cnt0, 32'd0);
    chk("t6_stall_cnt1", stall_cnt1, 32'd0);
    chk("t6_pkt_cnt", pkt_cnt, 32'd0);
`endif
    exp = {9'h170, 9'h171};
    chk_q("t6_b0", q0, exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
